// File: rtl/updown_modn_counter_pkg.sv
// Shared constants, next-state action encoding and parameter legality check
// for the parametrised up/down modulo-N counter.
package updown_modn_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   localparam int MAX_WIDTH = 16;

   // What the counter does at the next edge, already resolved for priority.
   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_STEP,
      ACT_WRAP,
      ACT_SATURATE
   } action_t;

   // MODULUS must fit the count range 0..MODULUS-1 into WIDTH bits.
   function automatic bit params_legal(input int width, input int modulus);
      return (width >= 1) && (width <= MAX_WIDTH) &&
             (modulus >= 2) && ($clog2(modulus) <= width);
   endfunction

endpackage

// File: rtl/updown_counter_slice.sv
// One counter bit: a JK flip-flop whose J/K are muxed between parallel set
// and toggle, plus ripple of the carry (up) or borrow (down) to the next bit.
module updown_counter_slice
   import updown_modn_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic set_val,
   input  logic toggle_in,
   input  logic up,
   output logic q,
   output logic toggle_out
);

   logic j;
   logic k;

   // A parallel set forces J/K to drive the bit to set_val; otherwise J = K = toggle.
   assign j = set ? set_val  : toggle_in;
   assign k = set ? ~set_val : toggle_in;

   // NOTE: sequential state uses non-blocking assignments so every bit of the
   // chain samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         unique case ({j, k})
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   // Counting up, the next bit toggles when this one is 1; counting down, when 0.
   assign toggle_out = toggle_in & ((up == DIR_UP) ? q : ~q);

endmodule

// File: rtl/updown_modn_counter.sv
// Parametrised up/down modulo-N counter with clear, clamped load, wrap or
// saturate boundary mode, combinational cascade tc and sticky ovf.
module updown_modn_counter
   import updown_modn_counter_pkg::*;
#(
   parameter int WIDTH   = 5,
   parameter int MODULUS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             updown,
   input  logic             sat,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);

   if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
      $error("updown_modn_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
   end

   localparam logic [WIDTH-1:0] MAX_COUNT  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO_COUNT = '0;

   logic             at_max;
   logic             at_min;
   logic             at_boundary;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] wrap_val;
   action_t          action;
   logic             set;
   logic [WIDTH-1:0] set_val;
   logic             step;
   logic [WIDTH:0]   toggle_chain;
   logic             unused_carry;

   assign at_max      = (count == MAX_COUNT);
   assign at_min      = (count == ZERO_COUNT);
   assign at_boundary = (updown == DIR_UP) ? at_max : at_min;

   // Zero-latency so a downstream stage enabled by tc advances on this same edge.
   assign tc = en & at_boundary;

   // Comparing against MODULUS-1 keeps the check at WIDTH bits even when MODULUS = 2^WIDTH.
   assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
   assign wrap_val     = (updown == DIR_DOWN) ? MAX_COUNT : ZERO_COUNT;

   // NOTE: every variable assigned in an always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      action = ACT_HOLD;
      if (clr) begin
         action = ACT_CLEAR;
      end else if (load) begin
         action = ACT_LOAD;
      end else if (en) begin
         if (!at_boundary) begin
            action = ACT_STEP;
         end else if (sat == MODE_SAT) begin
            action = ACT_SATURATE;
         end else begin
            action = ACT_WRAP;
         end
      end
   end

   // Clear, load and wrap all go through the parallel-set path; only an
   // in-range step ripples through the toggle chain.
   always_comb begin
      set     = 1'b0;
      set_val = ZERO_COUNT;
      step    = 1'b0;
      unique case (action)
         ACT_CLEAR: begin
            set     = 1'b1;
            set_val = ZERO_COUNT;
         end
         ACT_LOAD: begin
            set     = 1'b1;
            set_val = load_clamped;
         end
         ACT_WRAP: begin
            set     = 1'b1;
            set_val = wrap_val;
         end
         ACT_STEP: step = 1'b1;
         default:  ;
      endcase
   end

   assign toggle_chain[0] = step;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      updown_counter_slice u_slice (
         .clk        (clk),
         .rst        (rst),
         .set        (set),
         .set_val    (set_val[i]),
         .toggle_in  (toggle_chain[i]),
         .up         (updown),
         .q          (count[i]),
         .toggle_out (toggle_chain[i+1])
      );
   end

   // Roll-over past the MSB never happens: boundaries are handled by the set path.
   assign unused_carry = toggle_chain[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else begin
         unique case (action)
            ACT_CLEAR:              ovf <= 1'b0;
            ACT_WRAP, ACT_SATURATE: ovf <= 1'b1;
            default:                ovf <= ovf;
         endcase
      end
   end

endmodule

// File: tb/tb_updown_modn_counter.sv
// Self-checking bench: a decimal (W4/M10) counter, a two-digit cascade and a
// full-binary (W5/M32) counter, each compared every cycle with an integer model.
module tb_updown_modn_counter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       a_clr, a_load, a_en, a_up, a_sat;
   logic [3:0] a_load_val, a_count;
   logic       a_tc, a_ovf;

   logic       c_clr, c_en, c_up, c_sat;
   logic [3:0] c0_count, c1_count;
   logic       c0_tc, c1_tc, c0_ovf, c1_ovf;

   logic       b_clr, b_load, b_en, b_up, b_sat;
   logic [4:0] b_load_val, b_count;
   logic       b_tc, b_ovf;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   int ma_cnt = 0, ma_ovf = 0;
   int mc0_cnt = 0, mc0_ovf = 0, mc1_cnt = 0, mc1_ovf = 0;
   int mb_cnt = 0, mb_ovf = 0;

   always #5 clk = ~clk;

   updown_modn_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
      .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
      .en(a_en), .updown(a_up), .sat(a_sat), .count(a_count), .tc(a_tc), .ovf(a_ovf)
   );

   updown_modn_counter #(.WIDTH(4), .MODULUS(10)) u_stage0 (
      .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
      .en(c_en), .updown(c_up), .sat(c_sat), .count(c0_count), .tc(c0_tc), .ovf(c0_ovf)
   );

   updown_modn_counter #(.WIDTH(4), .MODULUS(10)) u_stage1 (
      .clk(clk), .rst(rst), .clr(c_clr), .load(1'b0), .load_val(4'd0),
      .en(c0_tc), .updown(c_up), .sat(c_sat), .count(c1_count), .tc(c1_tc), .ovf(c1_ovf)
   );

   updown_modn_counter #(.WIDTH(5), .MODULUS(32)) u_dut_b (
      .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_load_val),
      .en(b_en), .updown(b_up), .sat(b_sat), .count(b_count), .tc(b_tc), .ovf(b_ovf)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int model_tc(input int cnt, input bit en, input bit up, input int modn);
      return (en && (up ? (cnt == modn - 1) : (cnt == 0))) ? 1 : 0;
   endfunction

   function automatic int next_count(input int cnt, input bit clr, input bit load, input int lv,
                                     input bit en, input bit up, input bit sat, input int modn);
      if (clr)  return 0;
      if (load) return (lv >= modn) ? modn - 1 : lv;
      if (!en)  return cnt;
      if (up)   return (cnt < modn - 1) ? cnt + 1 : (sat ? cnt : 0);
      return (cnt > 0) ? cnt - 1 : (sat ? 0 : modn - 1);
   endfunction

   function automatic int next_ovf(input int cnt, input int ovf, input bit clr, input bit load,
                                   input bit en, input bit up, input int modn);
      if (clr)  return 0;
      if (load) return ovf;
      if (model_tc(cnt, en, up, modn) != 0) return 1;
      return ovf;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma_cnt <= 0;  ma_ovf <= 0;
         mc0_cnt <= 0; mc0_ovf <= 0;
         mc1_cnt <= 0; mc1_ovf <= 0;
         mb_cnt <= 0;  mb_ovf <= 0;
      end else begin
         ma_cnt  <= next_count(ma_cnt, a_clr, a_load, int'(a_load_val), a_en, a_up, a_sat, 10);
         ma_ovf  <= next_ovf(ma_cnt, ma_ovf, a_clr, a_load, a_en, a_up, 10);
         mc0_cnt <= next_count(mc0_cnt, c_clr, 1'b0, 0, c_en, c_up, c_sat, 10);
         mc0_ovf <= next_ovf(mc0_cnt, mc0_ovf, c_clr, 1'b0, c_en, c_up, 10);
         mc1_cnt <= next_count(mc1_cnt, c_clr, 1'b0, 0, model_tc(mc0_cnt, c_en, c_up, 10) != 0,
                               c_up, c_sat, 10);
         mc1_ovf <= next_ovf(mc1_cnt, mc1_ovf, c_clr, 1'b0,
                             model_tc(mc0_cnt, c_en, c_up, 10) != 0, c_up, 10);
         mb_cnt  <= next_count(mb_cnt, b_clr, b_load, int'(b_load_val), b_en, b_up, b_sat, 32);
         mb_ovf  <= next_ovf(mb_cnt, mb_ovf, b_clr, b_load, b_en, b_up, 32);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("a_count", int'(a_count), ma_cnt);
         check("a_ovf",   int'(a_ovf),   ma_ovf);
         check("a_tc",    int'(a_tc),    model_tc(ma_cnt, a_en, a_up, 10));
         check("c0_count", int'(c0_count), mc0_cnt);
         check("c0_ovf",   int'(c0_ovf),   mc0_ovf);
         check("c0_tc",    int'(c0_tc),    model_tc(mc0_cnt, c_en, c_up, 10));
         check("c1_count", int'(c1_count), mc1_cnt);
         check("c1_ovf",   int'(c1_ovf),   mc1_ovf);
         check("c1_tc",    int'(c1_tc),
               model_tc(mc1_cnt, model_tc(mc0_cnt, c_en, c_up, 10) != 0, c_up, 10));
         check("b_count", int'(b_count), mb_cnt);
         check("b_ovf",   int'(b_ovf),   mb_ovf);
         check("b_tc",    int'(b_tc),    model_tc(mb_cnt, b_en, b_up, 32));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dn_cnt[4];
      int dn_ovf[4];
      int dn_tc[4];

      {a_clr, a_load, a_en, a_up, a_sat} = '0;
      a_load_val = '0;
      {c_clr, c_en, c_up, c_sat} = '0;
      {b_clr, b_load, b_en, b_up, b_sat} = '0;
      b_load_val = '0;

      #1 rst = 1'b1;
      tick();
      chk_on = 1'b1;
      check("reset_a_count", int'(a_count), 0);
      check("reset_b_ovf", int'(b_ovf), 0);
      tick();
      rst = 1'b0;

      // Asynchronous reset in the middle of a count at 13.
      b_en = 1'b1;
      b_up = 1'b1;
      repeat (13) tick();
      check("pre_reset_b_count", int'(b_count), 13);
      rst = 1'b1;
      #1;
      check("async_reset_b_count", int'(b_count), 0);
      check("async_reset_b_ovf", int'(b_ovf), 0);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("post_reset_b_count", int'(b_count), i);
      end
      b_en = 1'b0;

      // Decimal up-count with wrap.
      a_en = 1'b1;
      a_up = 1'b1;
      a_sat = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("up_wrap_count", int'(a_count), (i + 1) % 10);
         check("up_wrap_tc", int'(a_tc), (i == 8) ? 1 : 0);
         check("up_wrap_ovf", int'(a_ovf), (i >= 9) ? 1 : 0);
      end
      a_en = 1'b0;

      // Down-count into saturation at 0.
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      check("clear_a_count", int'(a_count), 0);
      check("clear_a_ovf", int'(a_ovf), 0);
      a_load = 1'b1;
      a_load_val = 4'd2;
      tick();
      a_load = 1'b0;
      check("load2_count", int'(a_count), 2);
      dn_cnt = '{1, 0, 0, 0};
      dn_ovf = '{0, 0, 1, 1};
      dn_tc  = '{0, 1, 1, 1};
      a_en = 1'b1;
      a_up = 1'b0;
      a_sat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("down_sat_count", int'(a_count), dn_cnt[i]);
         check("down_sat_ovf", int'(a_ovf), dn_ovf[i]);
         check("down_sat_tc", int'(a_tc), dn_tc[i]);
      end
      a_en = 1'b0;

      // Load clamp, load at a boundary, clear beating load.
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      a_load = 1'b1;
      a_load_val = 4'd15;
      a_en = 1'b1;
      a_up = 1'b1;
      a_sat = 1'b0;
      tick();
      check("load_clamp_count", int'(a_count), 9);
      check("load_clamp_ovf", int'(a_ovf), 0);
      a_load_val = 4'd3;
      tick();
      check("load_at_boundary_count", int'(a_count), 3);
      check("load_at_boundary_ovf", int'(a_ovf), 0);
      a_load_val = 4'd9;
      a_en = 1'b0;
      tick();
      a_load = 1'b0;
      a_en = 1'b1;
      a_sat = 1'b1;
      tick();
      check("sat_hold_count", int'(a_count), 9);
      check("sat_hold_ovf", int'(a_ovf), 1);
      a_clr = 1'b1;
      a_load = 1'b1;
      a_load_val = 4'd5;
      tick();
      check("clr_over_load_count", int'(a_count), 0);
      check("clr_over_load_ovf", int'(a_ovf), 0);
      a_clr = 1'b0;
      a_load = 1'b0;
      a_sat = 1'b0;
      tick();
      check("dir_change_up", int'(a_count), 1);
      a_up = 1'b0;
      tick();
      check("dir_change_down", int'(a_count), 0);
      a_en = 1'b0;

      // Two-digit decimal cascade.
      c_en = 1'b1;
      c_up = 1'b1;
      c_sat = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         check("cascade_pair", int'(c1_count) * 10 + int'(c0_count), i % 100);
         if (i == 99) check("cascade_ovf_before", int'(c1_ovf), 0);
         if (i == 100) check("cascade_ovf_after", int'(c1_ovf), 1);
      end
      c_en = 1'b0;

      // Full-binary range: down from 0 wraps to 31.
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      b_en = 1'b1;
      b_up = 1'b0;
      b_sat = 1'b0;
      tick();
      check("binary_down_wrap_count", int'(b_count), 31);
      check("binary_down_wrap_ovf", int'(b_ovf), 1);
      b_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("binary_hold_count", int'(b_count), 31);
      end
      b_en = 1'b1;
      b_up = 1'b1;
      tick();
      check("binary_up_wrap_count", int'(b_count), 0);
      check("binary_up_wrap_ovf", int'(b_ovf), 1);
      b_en = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
